// File: rtl/sdram_burst_arbiter.sv
`timescale 1ns/1ps
// Upstream arbiter for the SDRAM controller: issues write/read bursts from FIFO fill levels,
// round-robins under contention, and steps burst addresses with wrap inside each window.
//
// state      | meaning
// S_IDLE     | no burst in flight; apply loads, pick the next burst
// S_WR_REQ   | sdram_wr_req high, waiting for the first write ack
// S_WR_BURST | write burst running, waiting for the ack to fall
// S_RD_REQ   | sdram_rd_req high, waiting for the first read ack
// S_RD_BURST | read burst running, waiting for the ack to fall
module sdram_burst_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int BURST_W    = 10,
    parameter int CNT_W      = 10,
    parameter int RD_ACK_DLY = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               sdram_init_done_i,
    input  logic [ADDR_W-1:0]  wr_min_addr_i,
    input  logic [ADDR_W-1:0]  wr_max_addr_i,
    input  logic [BURST_W-1:0] wr_len_i,
    input  logic               wr_load_i,
    input  logic [CNT_W-1:0]   wrf_used_i,
    output logic               wrf_rden_o,
    input  logic [ADDR_W-1:0]  rd_min_addr_i,
    input  logic [ADDR_W-1:0]  rd_max_addr_i,
    input  logic [BURST_W-1:0] rd_len_i,
    input  logic               rd_load_i,
    input  logic               rd_valid_i,
    input  logic [CNT_W-1:0]   rdf_used_i,
    output logic               rdf_wren_o,
    output logic               sdram_wr_req_o,
    input  logic               sdram_wr_ack_i,
    output logic [ADDR_W-1:0]  sdram_wr_addr_o,
    output logic [BURST_W-1:0] sdram_wr_burst_o,
    output logic               sdram_rd_req_o,
    input  logic               sdram_rd_ack_i,
    output logic [ADDR_W-1:0]  sdram_rd_addr_o,
    output logic [BURST_W-1:0] sdram_rd_burst_o
);

    localparam int CMP_W = (CNT_W > BURST_W) ? CNT_W : BURST_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_BURST,
        S_RD_REQ,
        S_RD_BURST
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              init_seen_q;
    logic              last_wr_q;
    logic              wr_load_seen_q;
    logic              rd_load_seen_q;
    logic              wr_ack_prev_q;
    logic              rd_ack_prev_q;

    logic              wr_pend_d;
    logic              rd_pend_d;
    logic              wr_fall_d;
    logic              rd_fall_d;
    logic [ADDR_W:0]   wr_sum_d;
    logic [ADDR_W:0]   rd_sum_d;
    logic              wr_wrap_d;
    logic              rd_wrap_d;

    assign wr_pend_d = sdram_init_done_i & ~wr_load_i
                     & (CMP_W'(wrf_used_i) >= CMP_W'(wr_len_i));
    assign rd_pend_d = sdram_init_done_i & ~rd_load_i & rd_valid_i
                     & (CMP_W'(rdf_used_i) < CMP_W'(rd_len_i));

    assign wr_fall_d = wr_ack_prev_q & ~sdram_wr_ack_i;
    assign rd_fall_d = rd_ack_prev_q & ~sdram_rd_ack_i;

    // One extra bit so a step past the top of the address space still compares as a wrap.
    assign wr_sum_d  = {1'b0, wr_addr_q} + (ADDR_W+1)'(sdram_wr_burst_o);
    assign rd_sum_d  = {1'b0, rd_addr_q} + (ADDR_W+1)'(sdram_rd_burst_o);
    assign wr_wrap_d = wr_sum_d >= {1'b0, wr_max_addr_i};
    assign rd_wrap_d = rd_sum_d >= {1'b0, rd_max_addr_i};

    assign wrf_rden_o = sdram_wr_ack_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= S_IDLE;
            wr_addr_q        <= '0;
            rd_addr_q        <= '0;
            init_seen_q      <= 1'b0;
            last_wr_q        <= 1'b0;
            wr_load_seen_q   <= 1'b0;
            rd_load_seen_q   <= 1'b0;
            wr_ack_prev_q    <= 1'b0;
            rd_ack_prev_q    <= 1'b0;
            sdram_wr_req_o   <= 1'b0;
            sdram_wr_addr_o  <= '0;
            sdram_wr_burst_o <= '0;
            sdram_rd_req_o   <= 1'b0;
            sdram_rd_addr_o  <= '0;
            sdram_rd_burst_o <= '0;
        end else begin
            wr_ack_prev_q <= sdram_wr_ack_i;
            rd_ack_prev_q <= sdram_rd_ack_i;
            if (!init_seen_q) begin
                if (sdram_init_done_i) begin
                    init_seen_q <= 1'b1;
                    wr_addr_q   <= wr_min_addr_i;
                    rd_addr_q   <= rd_min_addr_i;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (wr_load_i) wr_addr_q <= wr_min_addr_i;
                        if (rd_load_i) rd_addr_q <= rd_min_addr_i;
                        // Under contention the side that did not go last wins.
                        if (wr_pend_d && (!rd_pend_d || !last_wr_q)) begin
                            state_q          <= S_WR_REQ;
                            sdram_wr_req_o   <= 1'b1;
                            sdram_wr_addr_o  <= wr_addr_q;
                            sdram_wr_burst_o <= wr_len_i;
                        end else if (rd_pend_d) begin
                            state_q          <= S_RD_REQ;
                            sdram_rd_req_o   <= 1'b1;
                            sdram_rd_addr_o  <= rd_addr_q;
                            sdram_rd_burst_o <= rd_len_i;
                        end
                    end
                    S_WR_REQ: begin
                        if (wr_load_i) wr_load_seen_q <= 1'b1;
                        if (sdram_wr_ack_i) begin
                            sdram_wr_req_o <= 1'b0;
                            state_q        <= S_WR_BURST;
                        end
                    end
                    S_WR_BURST: begin
                        if (wr_fall_d) begin
                            state_q        <= S_IDLE;
                            last_wr_q      <= 1'b1;
                            wr_load_seen_q <= 1'b0;
                            if (wr_load_seen_q || wr_load_i || wr_wrap_d)
                                wr_addr_q <= wr_min_addr_i;
                            else
                                wr_addr_q <= wr_sum_d[ADDR_W-1:0];
                        end else if (wr_load_i) begin
                            wr_load_seen_q <= 1'b1;
                        end
                    end
                    S_RD_REQ: begin
                        if (rd_load_i) rd_load_seen_q <= 1'b1;
                        if (sdram_rd_ack_i) begin
                            sdram_rd_req_o <= 1'b0;
                            state_q        <= S_RD_BURST;
                        end
                    end
                    S_RD_BURST: begin
                        if (rd_fall_d) begin
                            state_q        <= S_IDLE;
                            last_wr_q      <= 1'b0;
                            rd_load_seen_q <= 1'b0;
                            if (rd_load_seen_q || rd_load_i || rd_wrap_d)
                                rd_addr_q <= rd_min_addr_i;
                            else
                                rd_addr_q <= rd_sum_d[ADDR_W-1:0];
                        end else if (rd_load_i) begin
                            rd_load_seen_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Read data lands on sdram_dout RD_ACK_DLY cycles after its ack.
    generate
        if (RD_ACK_DLY == 0) begin : g_no_dly
            assign rdf_wren_o = sdram_rd_ack_i;
        end else begin : g_dly
            logic [RD_ACK_DLY-1:0] ack_sr_q;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) ack_sr_q <= '0;
                else          ack_sr_q <= (ack_sr_q << 1) | RD_ACK_DLY'(sdram_rd_ack_i);
            end
            assign rdf_wren_o = ack_sr_q[RD_ACK_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
`timescale 1ns/1ps
// Bench for sdram_burst_arbiter: a behavioural SDRAM controller answers requests with random
// latency, and grants/addresses are compared against a window-stepping reference model.
module tb_sdram_burst_arbiter;
    localparam int ADDR_W = 24, BURST_W = 10, CNT_W = 10, RD_ACK_DLY = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, sdram_init_done, wr_load, rd_load, rd_valid;
    logic [ADDR_W-1:0]  wr_min, wr_max, rd_min, rd_max;
    logic [BURST_W-1:0] wr_len, rd_len;
    logic [CNT_W-1:0]   wrf_used, rdf_used;
    logic               wrf_rden, rdf_wren, wr_ack, rd_ack;
    logic               sdram_wr_req, sdram_rd_req;
    logic [ADDR_W-1:0]  sdram_wr_addr, sdram_rd_addr;
    logic [BURST_W-1:0] sdram_wr_burst, sdram_rd_burst;

    sdram_burst_arbiter #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .CNT_W(CNT_W),
                          .RD_ACK_DLY(RD_ACK_DLY)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .sdram_init_done_i(sdram_init_done),
        .wr_min_addr_i(wr_min), .wr_max_addr_i(wr_max), .wr_len_i(wr_len),
        .wr_load_i(wr_load), .wrf_used_i(wrf_used), .wrf_rden_o(wrf_rden),
        .rd_min_addr_i(rd_min), .rd_max_addr_i(rd_max), .rd_len_i(rd_len),
        .rd_load_i(rd_load), .rd_valid_i(rd_valid), .rdf_used_i(rdf_used), .rdf_wren_o(rdf_wren),
        .sdram_wr_req_o(sdram_wr_req), .sdram_wr_ack_i(wr_ack),
        .sdram_wr_addr_o(sdram_wr_addr), .sdram_wr_burst_o(sdram_wr_burst),
        .sdram_rd_req_o(sdram_rd_req), .sdram_rd_ack_i(rd_ack),
        .sdram_rd_addr_o(sdram_rd_addr), .sdram_rd_burst_o(sdram_rd_burst));

    typedef struct { bit is_wr; int addr; int len; } gnt_t;
    gnt_t glog[$];

    int n_cmp = 0, n_err = 0;
    int wr_pulses = 0, rd_pulses = 0, overlap = 0, dly_err = 0, req_cycles = 0, reqhold_err = 0;
    int ctl_mode = 0;

    // Controller model: accepts a request, waits 0..3 cycles, then acks once per word.
    initial begin
        gnt_t g;
        bit   ctl_wr;
        int   ctl_lat, ctl_rem;
        wr_ack = 1'b0; rd_ack = 1'b0; ctl_wr = 1'b0; ctl_lat = 0; ctl_rem = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                wr_ack = 1'b0; rd_ack = 1'b0; ctl_mode = 0;
            end else begin
                case (ctl_mode)
                    0: begin
                        if (sdram_wr_req || sdram_rd_req) begin
                            ctl_wr = sdram_wr_req;
                            g.is_wr = ctl_wr;
                            g.addr = ctl_wr ? int'(sdram_wr_addr) : int'(sdram_rd_addr);
                            g.len  = ctl_wr ? int'(sdram_wr_burst) : int'(sdram_rd_burst);
                            glog.push_back(g);
                            ctl_rem = g.len;
                            ctl_lat = $urandom_range(0, 3);
                            ctl_mode = 1;
                        end
                    end
                    1: begin
                        if ((ctl_wr ? sdram_wr_req : sdram_rd_req) !== 1'b1) reqhold_err++;
                        if (ctl_lat == 0) begin
                            if (ctl_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
                            ctl_rem--;
                            ctl_mode = 2;
                        end else ctl_lat--;
                    end
                    default: begin
                        if ((ctl_wr ? sdram_wr_req : sdram_rd_req) !== 1'b0) reqhold_err++;
                        if (ctl_rem == 0) begin
                            wr_ack = 1'b0; rd_ack = 1'b0; ctl_mode = 0;
                        end else ctl_rem--;
                    end
                endcase
            end
        end
    end

    initial begin
        bit prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) prev_ack = 1'b0;
            else begin
                if (wrf_rden) wr_pulses++;
                if (rdf_wren) rd_pulses++;
                if (sdram_wr_req && sdram_rd_req) overlap++;
                if (sdram_wr_req || sdram_rd_req) req_cycles++;
                if (rdf_wren !== prev_ack) dly_err++;
                prev_ack = rd_ack;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: sim time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic int step_addr(input int a, input int len, input int mn, input int mx);
        return (a + len >= mx) ? mn : a + len;
    endfunction

    task automatic set_defaults();
        wr_load = 1'b0; rd_load = 1'b0; rd_valid = 1'b0; wrf_used = '0; rdf_used = '0;
        wr_min = '0; wr_max = 24'd1024; rd_min = '0; rd_max = 24'd1024;
        wr_len = 10'd1; rd_len = 10'd1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; sdram_init_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_grants(input int target, input int budget, output bit to);
        int c;
        c = 0; to = 1'b0;
        while (glog.size() < target) begin
            if (c >= budget) begin to = 1'b1; break; end
            @(negedge clk); c++;
        end
    endtask

    task automatic wait_quiet(input int budget, output bit to);
        int c, q;
        c = 0; q = 0; to = 1'b0;
        while (q < 3) begin
            if (c >= budget) begin to = 1'b1; break; end
            @(negedge clk); c++;
            if (ctl_mode == 0 && !sdram_wr_req && !sdram_rd_req) q++; else q = 0;
        end
    endtask

    task automatic test_reset();
        set_defaults();
        wrf_used = '1; rd_valid = 1'b1; rst_n = 1'b0; sdram_init_done = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (sdram_wr_req !== 1'b0) begin n_err++; $display("FAIL reset_wr_req: got %b want 0", sdram_wr_req); end
        n_cmp++; if (sdram_rd_req !== 1'b0) begin n_err++; $display("FAIL reset_rd_req: got %b want 0", sdram_rd_req); end
        n_cmp++; if (sdram_wr_addr !== '0) begin n_err++; $display("FAIL reset_wr_addr: got %h want 0", sdram_wr_addr); end
        n_cmp++; if (sdram_rd_addr !== '0) begin n_err++; $display("FAIL reset_rd_addr: got %h want 0", sdram_rd_addr); end
        n_cmp++; if ({sdram_wr_burst, sdram_rd_burst} !== '0) begin n_err++; $display("FAIL reset_bursts: got %h/%h want 0", sdram_wr_burst, sdram_rd_burst); end
        n_cmp++; if ({wrf_rden, rdf_wren} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b%b want 00", wrf_rden, rdf_wren); end
    endtask

    task automatic test_write_only();
        int base, p0, r0, ov0, exp_a; bit to, tq;
        set_defaults();
        wr_len = 10'd256; wrf_used = 10'd300;
        apply_reset();
        base = glog.size(); p0 = wr_pulses; r0 = rd_pulses; ov0 = overlap;
        sdram_init_done = 1'b1;
        wait_grants(base + 5, 20000, to);
        wrf_used = '0;
        wait_quiet(3000, tq);
        n_cmp++; if (to || tq) begin n_err++; $display("FAIL wr_only_timeout: grants %0d want 5", glog.size() - base); end
        exp_a = 0;
        for (int i = 0; i < 5 && base + i < glog.size(); i++) begin
            n_cmp++;
            if (glog[base+i].is_wr !== 1'b1 || glog[base+i].addr !== exp_a || glog[base+i].len !== 256) begin
                n_err++;
                $display("FAIL wr_only_grant%0d: got wr=%0d addr=%0d len=%0d want wr=1 addr=%0d len=256",
                         i, glog[base+i].is_wr, glog[base+i].addr, glog[base+i].len, exp_a);
            end
            exp_a = step_addr(exp_a, 256, 0, 1024);
        end
        n_cmp++; if (wr_pulses - p0 !== 5 * 256) begin n_err++; $display("FAIL wr_only_rden: got %0d want %0d", wr_pulses - p0, 5 * 256); end
        n_cmp++; if (rd_pulses - r0 !== 0 || overlap - ov0 !== 0) begin n_err++; $display("FAIL wr_only_side: rd pulses %0d overlap %0d want 0/0", rd_pulses - r0, overlap - ov0); end
    endtask

    task automatic test_read_prefetch();
        int base, p0, w0, d0, mn; bit to, tq;
        set_defaults();
        mn = 4096 + $urandom_range(0, 255);
        rd_min = ADDR_W'(mn); rd_max = ADDR_W'(mn + 4096); rd_len = 10'd128;
        rd_valid = 1'b1; rdf_used = '0;
        apply_reset();
        base = glog.size(); p0 = rd_pulses; w0 = wr_pulses; d0 = dly_err;
        sdram_init_done = 1'b1;
        wait_grants(base + 1, 2000, to);
        rd_valid = 1'b0;
        wait_quiet(2000, tq);
        n_cmp++; if (to || tq) begin n_err++; $display("FAIL rd_pref_timeout: grants %0d want 1", glog.size() - base); end
        if (base < glog.size()) begin
            n_cmp++;
            if (glog[base].is_wr !== 1'b0 || glog[base].addr !== mn || glog[base].len !== 128) begin
                n_err++;
                $display("FAIL rd_pref_grant: got wr=%0d addr=%0d len=%0d want wr=0 addr=%0d len=128",
                         glog[base].is_wr, glog[base].addr, glog[base].len, mn);
            end
        end
        n_cmp++; if (rd_pulses - p0 !== 128) begin n_err++; $display("FAIL rd_pref_wren_count: got %0d want 128", rd_pulses - p0); end
        n_cmp++; if (dly_err - d0 !== 0) begin n_err++; $display("FAIL rd_pref_wren_delay: %0d cycles differ from ack delayed by 1, want 0", dly_err - d0); end
        n_cmp++; if (wr_pulses - w0 !== 0) begin n_err++; $display("FAIL rd_pref_wr_side: got %0d wr pulses want 0", wr_pulses - w0); end
    endtask

    // mode 0: writes only, 1: reads only, 2: both pending (round-robin, writes first after reset)
    task automatic run_mixed(input string tag, input int mode, input int ngr);
        int base, w0, r0, ov0, d0, h0, wmn, wmx, rmn, rmx, wl, rl, wa, ra, wsum, rsum;
        bit to, tq, exp_wr;
        set_defaults();
        wmn = $urandom_range(0, 5000); wmx = wmn + $urandom_range(64, 700); wl = $urandom_range(1, 300);
        rmn = $urandom_range(0, 5000); rmx = rmn + $urandom_range(64, 700); rl = $urandom_range(1, 300);
        wr_min = ADDR_W'(wmn); wr_max = ADDR_W'(wmx); wr_len = BURST_W'(wl);
        rd_min = ADDR_W'(rmn); rd_max = ADDR_W'(rmx); rd_len = BURST_W'(rl);
        wrf_used = (mode != 1) ? CNT_W'($urandom_range(wl, 1023)) : CNT_W'($urandom_range(0, wl - 1));
        rd_valid = 1'b1;
        rdf_used = (mode != 0) ? CNT_W'($urandom_range(0, rl - 1)) : CNT_W'($urandom_range(rl, 1023));
        apply_reset();
        base = glog.size(); w0 = wr_pulses; r0 = rd_pulses; ov0 = overlap; d0 = dly_err; h0 = reqhold_err;
        sdram_init_done = 1'b1;
        wait_grants(base + ngr, 600 * ngr, to);
        rd_valid = 1'b0; wrf_used = '0;
        wait_quiet(2000, tq);
        n_cmp++; if (to || tq) begin n_err++; $display("FAIL %s_timeout: grants %0d want %0d", tag, glog.size() - base, ngr); end
        wa = wmn; ra = rmn; wsum = 0; rsum = 0;
        for (int i = 0; i < ngr && base + i < glog.size(); i++) begin
            exp_wr = (mode == 0) || (mode == 2 && (i % 2 == 0));
            n_cmp++;
            if (glog[base+i].is_wr !== exp_wr || glog[base+i].addr !== (exp_wr ? wa : ra)
                || glog[base+i].len !== (exp_wr ? wl : rl)) begin
                n_err++;
                $display("FAIL %s_grant%0d: got wr=%0d addr=%0d len=%0d want wr=%0d addr=%0d len=%0d",
                         tag, i, glog[base+i].is_wr, glog[base+i].addr, glog[base+i].len,
                         exp_wr, exp_wr ? wa : ra, exp_wr ? wl : rl);
            end
            if (exp_wr) begin wa = step_addr(wa, wl, wmn, wmx); wsum += wl; end
            else        begin ra = step_addr(ra, rl, rmn, rmx); rsum += rl; end
        end
        n_cmp++; if (wr_pulses - w0 !== wsum || rd_pulses - r0 !== rsum) begin n_err++; $display("FAIL %s_strobes: got wr=%0d rd=%0d want wr=%0d rd=%0d", tag, wr_pulses - w0, rd_pulses - r0, wsum, rsum); end
        n_cmp++; if (overlap - ov0 !== 0 || reqhold_err - h0 !== 0) begin n_err++; $display("FAIL %s_req_protocol: overlap=%0d reqhold=%0d want 0/0", tag, overlap - ov0, reqhold_err - h0); end
        n_cmp++; if (dly_err - d0 !== 0) begin n_err++; $display("FAIL %s_wren_delay: got %0d bad cycles want 0", tag, dly_err - d0); end
    endtask

    task automatic test_contention();
        run_mixed("contention", 2, 8);
    endtask

    task automatic test_random_windows();
        for (int k = 0; k < 3; k++) run_mixed("random", $urandom_range(0, 2), 6);
    endtask

    task automatic test_load_mid_burst();
        int base, p0, c; bit to, tq, tm;
        set_defaults();
        wr_len = 10'd256; wrf_used = 10'd300;
        apply_reset();
        base = glog.size(); p0 = wr_pulses;
        sdram_init_done = 1'b1;
        wait_grants(base + 3, 3000, to);
        c = 0; tm = 1'b0;
        while (ctl_mode != 2) begin
            if (c >= 20) begin tm = 1'b1; break; end
            @(negedge clk); c++;
        end
        wr_load = 1'b1;
        repeat (4) @(negedge clk);
        wr_load = 1'b0;
        wait_grants(base + 4, 1000, tq);
        wrf_used = '0;
        n_cmp++; if (to || tm || tq) begin n_err++; $display("FAIL load_timeout: grants %0d want 4", glog.size() - base); end
        wait_quiet(1000, tq);
        if (base + 3 < glog.size()) begin
            n_cmp++; if (glog[base+2].addr !== 512) begin n_err++; $display("FAIL load_pre_addr: got %0d want 512", glog[base+2].addr); end
            n_cmp++; if (glog[base+3].addr !== 0) begin n_err++; $display("FAIL load_next_addr: got %0d want 0", glog[base+3].addr); end
        end
        n_cmp++; if (wr_pulses - p0 !== 4 * 256) begin n_err++; $display("FAIL load_rden: got %0d want %0d", wr_pulses - p0, 4 * 256); end
    endtask

    task automatic test_rd_load();
        int base, mn, n1; bit to, tq, t2;
        set_defaults();
        mn = $urandom_range(100, 3000);
        rd_min = ADDR_W'(mn); rd_max = ADDR_W'(mn + 2000); rd_len = 10'd100; rd_valid = 1'b1;
        apply_reset();
        base = glog.size();
        sdram_init_done = 1'b1;
        wait_grants(base + 1, 500, to);
        rd_load = 1'b1;
        wait_quiet(1000, tq);
        repeat (200) @(negedge clk);
        n1 = glog.size() - base;
        rd_load = 1'b0;
        wait_grants(base + 2, 500, t2);
        rd_valid = 1'b0;
        wait_quiet(1000, tq);
        n_cmp++; if (to || t2) begin n_err++; $display("FAIL rd_load_timeout: grants %0d want 2", glog.size() - base); end
        n_cmp++; if (n1 !== 1) begin n_err++; $display("FAIL rd_load_block: got %0d grants while loading want 1", n1); end
        if (base + 1 < glog.size()) begin
            n_cmp++; if (glog[base+1].addr !== mn) begin n_err++; $display("FAIL rd_load_addr: got %0d want %0d", glog[base+1].addr, mn); end
        end
    endtask

    task automatic test_init_gate();
        int base, rc0, c; bit tq;
        set_defaults();
        wr_min = 24'd100; wr_len = 10'd256; wrf_used = '1; rd_valid = 1'b1; rd_len = 10'd16;
        apply_reset();
        base = glog.size(); rc0 = req_cycles;
        repeat (1000) @(negedge clk);
        n_cmp++; if (req_cycles - rc0 !== 0) begin n_err++; $display("FAIL init_gate_quiet: got %0d req cycles want 0", req_cycles - rc0); end
        sdram_init_done = 1'b1;
        c = 0;
        while (!(sdram_wr_req || sdram_rd_req) && c < 10) begin @(negedge clk); c++; end
        n_cmp++; if (c > 3) begin n_err++; $display("FAIL init_gate_latency: got %0d cycles want <=3", c); end
        wrf_used = '0; rd_valid = 1'b0;
        wait_quiet(1000, tq);
        if (base < glog.size()) begin
            n_cmp++; if (glog[base].is_wr !== 1'b1 || glog[base].addr !== 100) begin n_err++; $display("FAIL init_gate_first: got wr=%0d addr=%0d want wr=1 addr=100", glog[base].is_wr, glog[base].addr); end
        end
    endtask

    task automatic test_async_reset();
        int base, mn, c; bit to, tm, t2, tq;
        set_defaults();
        mn = $urandom_range(1000, 9000);
        rd_min = ADDR_W'(mn); rd_max = ADDR_W'(mn + 2048); rd_len = 10'd64; rd_valid = 1'b1;
        apply_reset();
        base = glog.size();
        sdram_init_done = 1'b1;
        wait_grants(base + 2, 1000, to);
        c = 0; tm = 1'b0;
        while (ctl_mode != 2) begin
            if (c >= 20) begin tm = 1'b1; break; end
            @(negedge clk); c++;
        end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (to || tm) begin n_err++; $display("FAIL areset_setup_timeout: grants %0d want 2", glog.size() - base); end
        n_cmp++; if ({sdram_wr_req, sdram_rd_req, rdf_wren, wrf_rden} !== 4'b0000) begin n_err++; $display("FAIL areset_ctrl: got req=%b%b strobes=%b%b want all 0", sdram_wr_req, sdram_rd_req, rdf_wren, wrf_rden); end
        n_cmp++; if (sdram_rd_addr !== '0 || sdram_rd_burst !== '0) begin n_err++; $display("FAIL areset_rd_outputs: got addr=%h burst=%h want 0/0", sdram_rd_addr, sdram_rd_burst); end
        sdram_init_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = glog.size();
        sdram_init_done = 1'b1;
        wait_grants(base + 1, 500, t2);
        rd_valid = 1'b0;
        wait_quiet(1000, tq);
        n_cmp++; if (t2) begin n_err++; $display("FAIL areset_restart_timeout: no grant after reset"); end
        if (base < glog.size()) begin
            n_cmp++; if (glog[base].is_wr !== 1'b0 || glog[base].addr !== mn) begin n_err++; $display("FAIL areset_restart_addr: got wr=%0d addr=%0d want wr=0 addr=%0d", glog[base].is_wr, glog[base].addr, mn); end
        end
    endtask

    initial begin
        rst_n = 1'b0; sdram_init_done = 1'b0;
        set_defaults();
        test_reset();
        test_write_only();
        test_read_prefetch();
        test_contention();
        test_random_windows();
        test_load_mid_burst();
        test_rd_load();
        test_init_gate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
